sd_wp_debounce: RTL
===================

SD_WP_DEBOUNCE -- requirements
Module: sd_wp_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive clk cycles the synchronised pin must differ before out_level changes; legal range 2..2^20.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flop count; legal range 2..4.
REQ-003 SHALL have parameter RESET_LEVEL, default 1'b1, value loaded into the synchroniser and out_level at reset (wp_n inactive).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_pin  input  1  raw, asynchronous, bouncing SD socket write-protect pin (active-low).
REQ-007 SHALL have port out_level  output  1  debounced level, drives the downstream PIO in_port.
REQ-008 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-009 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-010 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-011 SHALL have port readdata  output  32  Avalon-MM registered read data.
REQ-012 SHALL have port irq  output  1  edge interrupt, present only when SD_WP_DEBOUNCE_IRQ_EN is defined.

Function
REQ-013 SHALL pass in_pin through SYNC_STAGES flops; only the last stage (sync) is used downstream.
REQ-014 SHALL hold counter cnt of width clog2(DEBOUNCE_CYCLES+1); cnt clears whenever sync equals out_level.
REQ-015 SHALL increment cnt while sync differs from out_level; when cnt equals DEBOUNCE_CYCLES-1 and sync still differs, out_level SHALL take sync and cnt SHALL clear in the same cycle.
REQ-016 SHALL give pin-to-out_level latency of exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles for a clean step; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave out_level unchanged.
REQ-017 SHALL never saturate or wrap cnt; cnt never exceeds DEBOUNCE_CYCLES-1.
REQ-018 SHALL set edge_cap bit 0 in the cycle after out_level changes (either direction).
REQ-019 SHALL clear edge_cap when write_n=0, address=3, writedata[0]=1; simultaneous set and clear SHALL leave edge_cap set.
REQ-020 SHALL register readdata one cycle after address is presented: addr 0 -> {31'b0,out_level}; addr 1 -> 0; addr 2 -> {31'b0,irq_mask} (0 when macro absent); addr 3 -> {31'b0,edge_cap}.
REQ-021 SHALL ignore writes to addresses 0 and 1.

Reset
REQ-022 SHALL, while reset=1 at a clk edge, load all synchroniser stages and out_level with RESET_LEVEL, and clear cnt, edge_cap, irq_mask and readdata to 0.
REQ-023 SHALL, on reset mid-debounce, discard the pending count; no edge SHALL be recorded for the reset transition itself.

Configuration
REQ-024 With SD_WP_DEBOUNCE_IRQ_EN defined: irq_mask register at addr 2 SHALL be written from writedata[0], and irq SHALL equal edge_cap AND irq_mask, combinational from registers.
REQ-025 Without SD_WP_DEBOUNCE_IRQ_EN: no irq port, no irq_mask flop, addr 2 SHALL read 0 and ignore writes.

Structure
REQ-026 Shared package sd_card_pkg SHALL hold the register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGE=3) and the default DEBOUNCE_CYCLES constant.
REQ-027 Synchroniser SHALL be sub-module sd_pin_sync (parameters SYNC_STAGES, RESET_LEVEL); debounce, edge and register logic stay in sd_wp_debounce.

Verification (bench: DEBOUNCE_CYCLES=8, SYNC_STAGES=2, macro defined)
REQ-028 Reset held 3 cycles with in_pin=0 -> out_level=1, readdata=0, irq=0 throughout reset and first post-reset cycle.
REQ-029 in_pin 1->0 step at cycle T -> out_level falls exactly at T+10; edge_cap reads 1 at addr 3.
REQ-030 in_pin pulses low for 7 cycles then high -> out_level stays 1, edge_cap stays 0.
REQ-031 Write addr 2 data 1, trigger edge -> irq=1; write addr 3 data 1 -> irq=0 next cycle; write addr 3 in the same cycle as a new edge -> edge_cap remains 1.
REQ-032 Reset asserted at cnt=5 mid-debounce -> cnt=0, out_level=1, edge_cap=0; full 10-cycle latency required again afterwards.
REQ-033 Read addr 0/1/2/3 back-to-back -> each readdata valid one cycle after its address, addr 1 returns 0.

Source files
------------

// File: rtl/sd_card_pkg.sv
// Shared constants for the SD card support blocks: register map and default debounce length.
package sd_card_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    // 1 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/sd_wp_debounce_if.sv
// Avalon-MM slave bus of the SD write-protect debouncer.
// The irq wire exists only when SD_WP_DEBOUNCE_IRQ_EN is defined.
interface sd_wp_debounce_if;

    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

`ifdef SD_WP_DEBOUNCE_IRQ_EN
    logic        irq;

    modport master (output address, output write_n, output writedata,
                    input readdata, input irq);
    modport slave  (input address, input write_n, input writedata,
                    output readdata, output irq);
`else
    modport master (output address, output write_n, output writedata,
                    input readdata);
    modport slave  (input address, input write_n, input writedata,
                    output readdata);
`endif

endinterface

// File: rtl/sd_pin_sync.sv
// Multi-flop synchroniser for an asynchronous pin; only the last stage is exported.
module sd_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_stages;

    // Shift the raw pin through the chain; reset preloads the inactive level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stages <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/sd_wp_debounce.sv
// SD socket write-protect debouncer with an Avalon-MM status/edge register block.
// Define SD_WP_DEBOUNCE_IRQ_EN to add the irq_mask register (addr 2) and the irq output.
module sd_wp_debounce
    import sd_card_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_pin,
    output logic           out_level,
    sd_wp_debounce_if.slave bus
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_prev;
    logic             r_edge_cap;
    logic             w_edge;
    logic             w_wr;
    logic             w_edge_clr;
    logic             w_irq_mask;
    logic [31:0]      w_rdata;
    logic [31:0]      r_readdata;
    logic             w_unused_wdata;

    sd_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (in_pin),
        .o_sync (w_sync)
    );

    // Count consecutive cycles of disagreement; commit the new level on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= w_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_level = r_level;

    // Delayed copy of the level; reset loads both so the reset itself never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_prev <= RESET_LEVEL;
        end else begin
            r_level_prev <= r_level;
        end
    end

    assign w_edge     = r_level ^ r_level_prev;
    assign w_wr       = ~bus.write_n;
    assign w_edge_clr = w_wr && (bus.address == ADDR_EDGE) && bus.writedata[0];

    // Sticky edge flag; a new edge wins over a concurrent write-one-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_cap <= 1'b0;
        end else if (w_edge) begin
            r_edge_cap <= 1'b1;
        end else if (w_edge_clr) begin
            r_edge_cap <= 1'b0;
        end
    end

`ifdef SD_WP_DEBOUNCE_IRQ_EN
    logic r_irq_mask;

    // Interrupt mask register at ADDR_IRQMASK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= 1'b0;
        end else if (w_wr && (bus.address == ADDR_IRQMASK)) begin
            r_irq_mask <= bus.writedata[0];
        end
    end

    assign w_irq_mask = r_irq_mask;
    assign bus.irq    = r_edge_cap & r_irq_mask;
`else
    assign w_irq_mask = 1'b0;
`endif

    // Read mux; the reserved address and anything unmapped read as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (bus.address)
            ADDR_DATA:    w_rdata = {31'd0, r_level};
            ADDR_IRQMASK: w_rdata = {31'd0, w_irq_mask};
            ADDR_EDGE:    w_rdata = {31'd0, r_edge_cap};
            default:      w_rdata = 32'd0;
        endcase
    end

    // Registered read data, valid one cycle after the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;

    // Only bit 0 of the write data is meaningful.
    assign w_unused_wdata = ^bus.writedata[31:1];

endmodule
